// File: rtl/bus_sched_pkg.sv
// Shared state encoding, field widths and destination decode for bus_rr_scheduler.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam int DEST_W    = 8;
  localparam int PKT_MAX_W = 256;

  // Callers zero-extend the packet to PKT_MAX_W; pkt_w is the real packet width.
  function automatic logic [DEST_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int                   pkt_w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - DEST_W);
    return shifted[DEST_W-1:0];
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req bit strictly after ptr, wrapping.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic         vld,
  output logic [3:0]   idx
);

  // Descending scans let the lowest matching index win; the second scan
  // (indices above ptr) overrides the wrapped-around candidates.
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(ptr))) idx = 4'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(ptr))) idx = 4'(i);
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler/router: pops one device FIFO every 3 cycles and pushes the packet to its destination(s).
// Optional BUS_SCHED_STATS_EN adds saturating delivered/dropped packet counters.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic [3:0]               grant_id,
  output logic                     busy
`ifdef BUS_SCHED_STATS_EN
  ,
  output logic [15:0]              pkt_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  state_t               state, state_nxt;
  logic [3:0]           gnt;
  logic [3:0]           rr_ptr;
  logic [pckg_sz-1:0]   pkt_reg;
  logic [pckg_sz-1:0]   head;
  logic [DEST_W-1:0]    dest;
  logic [PKT_MAX_W-1:0] head_ext;
  logic [drvrs-1:0]     push_dec;
  logic [drvrs-1:0]     pop_nxt;
  logic [drvrs-1:0]     push_nxt;
  logic                 ld_gnt;
  logic                 ld_pkt;
  logic                 pick_vld;
  logic [3:0]           pick_idx;

  rr_picker #(.N(drvrs)) u_picker (
    .req (pndng),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = GRANT;
      GRANT:   state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_nxt  = '0;
    push_nxt = '0;
    ld_gnt   = 1'b0;
    ld_pkt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          ld_gnt = 1'b1;
          for (int i = 0; i < drvrs; i++) pop_nxt[i] = (pick_idx == 4'(i));
        end
      end
      GRANT: begin
        ld_pkt   = 1'b1;
        push_nxt = push_dec;
      end
      default: ;
    endcase
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (gnt == 4'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  always_comb begin
    head_ext                = '0;
    head_ext[pckg_sz-1:0]   = head;
  end

  assign dest = dest_of(head_ext, pckg_sz);

  // Out-of-range and self-addressed destinations match no bit and are dropped.
  always_comb begin
    push_dec = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (dest == broadcast) push_dec[i] = (gnt != 4'(i));
      else                   push_dec[i] = (dest == DEST_W'(i)) && (gnt != 4'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop      <= '0;
      push     <= '0;
      gnt      <= '0;
      rr_ptr   <= 4'(drvrs - 1);
      grant_id <= '0;
      pkt_reg  <= '0;
    end else begin
      pop  <= pop_nxt;
      push <= push_nxt;
      if (ld_gnt) gnt <= pick_idx;
      if (ld_pkt) begin
        pkt_reg  <= head;
        rr_ptr   <= gnt;
        grant_id <= gnt;
      end
    end
  end

  assign D_push = pkt_reg;
  assign busy   = (state != IDLE);

`ifdef BUS_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (state == DELIVER) begin
      if (|push) begin
        if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      end else begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: per-device FIFO queues feed the DUT, a queue-level model predicts grants and pushes.
module tb_bus_rr_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     pndng = '0;
  logic [N*W-1:0]   D_pop = '0;
  logic [N-1:0]     pop, push;
  logic [W-1:0]     D_push;
  logic [3:0]       grant_id;
  logic             busy;
`ifdef BUS_SCHED_STATS_EN
  logic [15:0]      pkt_cnt, drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] q[N][$];
  int defer_dev = -1;
  int cyc = 0;
  int m_last = N - 1;
  int exp_pkt = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  bus_rr_scheduler #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef BUS_SCHED_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  // Show-ahead FIFO outputs: pndng = non-empty, D_pop = head.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (q[i].size() > 0);
      D_pop[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 16'hDEAD;
    end
  endtask

  // A pop seen in one cycle is consumed by the FIFO at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (defer_dev >= 0) begin
      if (q[defer_dev].size() > 0) void'(q[defer_dev].pop_front());
      defer_dev = -1;
    end
    drive();
    for (int i = 0; i < N; i++) if (pop[i]) defer_dev = i;
  endtask

  task automatic wait_pop(input string name, output logic [N-1:0] pv);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (pop == '0 && n < 12);
    pv = pop;
    checks++;
    if (pop == '0) begin
      errors++;
      $display("FAIL %s_timeout: pop=%b after %0d cycles, required a grant", name, pop, n);
    end
  endtask

  function automatic int model_pick(input int last);
    for (int k = 1; k <= N; k++) begin
      if (q[(last + k) % N].size() > 0) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_push(input int src, input logic [W-1:0] pkt);
    int dest;
    logic [N-1:0] m;
    dest = int'(pkt[W-1:W-8]);
    m = '0;
    if (dest == 255) begin
      for (int i = 0; i < N; i++) m[i] = (i != src);
    end else if (dest < N && dest != src) begin
      m[dest] = 1'b1;
    end
    return m;
  endfunction

  function automatic void account(input logic [N-1:0] em);
    if (em != '0) exp_pkt++;
    else          exp_drop++;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    int r;
    logic [7:0] d;
    r = $urandom_range(0, 5);
    if (r < 4)       d = 8'(r);
    else if (r == 4) d = 8'hFF;
    else             d = 8'($urandom_range(4, 254));
    return {d, 8'($urandom_range(0, 255))};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop: got %b want 0000", pop); end
    checks++; if (push !== 4'b0000) begin errors++; $display("FAIL reset_push: got %b want 0000", push); end
    checks++; if (D_push !== 16'h0000) begin errors++; $display("FAIL reset_dpush: got %h want 0000", D_push); end
    checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_unicast();
    logic [N-1:0] pv, em;
    q[0].push_back(16'h02AB);
    drive();
    wait_pop("unicast", pv);
    em = model_push(0, 16'h02AB);
    checks++; if (pv !== 4'b0001) begin errors++; $display("FAIL unicast_pop: got %b want 0001", pv); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unicast_busy_grant: got %b want 1", busy); end
    tick();
    checks++; if (push !== 4'b0100) begin errors++; $display("FAIL unicast_push: got %b want 0100", push); end
    checks++; if (D_push !== 16'h02AB) begin errors++; $display("FAIL unicast_dpush: got %h want 02ab", D_push); end
    checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL unicast_grant_id: got %0d want 0", grant_id); end
    m_last = 0;
    account(em);
    tick();
    checks++; if (push !== 4'b0000) begin errors++; $display("FAIL unicast_push_one_cycle: got %b want 0000", push); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unicast_busy_idle: got %b want 0", busy); end
    checks++; if (D_push !== 16'h02AB) begin errors++; $display("FAIL unicast_dpush_hold: got %h want 02ab", D_push); end
  endtask

  task automatic test_broadcast();
    logic [N-1:0] pv;
    q[1].push_back(16'hFF55);
    drive();
    wait_pop("broadcast", pv);
    checks++; if (pv !== 4'b0010) begin errors++; $display("FAIL broadcast_pop: got %b want 0010", pv); end
    tick();
    checks++; if (push !== 4'b1101) begin errors++; $display("FAIL broadcast_push: got %b want 1101", push); end
    checks++; if (D_push !== 16'hFF55) begin errors++; $display("FAIL broadcast_dpush: got %h want ff55", D_push); end
    checks++; if (grant_id !== 4'd1) begin errors++; $display("FAIL broadcast_grant_id: got %0d want 1", grant_id); end
    m_last = 1;
    account(model_push(1, 16'hFF55));
    tick();
  endtask

  task automatic test_invalid_dest();
    logic [N-1:0] pv;
    q[3].push_back(16'h0712);
    drive();
    wait_pop("invalid", pv);
    checks++; if (pv !== 4'b1000) begin errors++; $display("FAIL invalid_pop: got %b want 1000", pv); end
    tick();
    checks++; if (push !== 4'b0000) begin errors++; $display("FAIL invalid_push: got %b want 0000", push); end
    m_last = 3;
    account(model_push(3, 16'h0712));
    tick();
`ifdef BUS_SCHED_STATS_EN
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL invalid_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    checks++; if (pkt_cnt !== 16'(exp_pkt)) begin errors++; $display("FAIL invalid_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
`endif
  endtask

  task automatic test_fairness();
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [N-1:0] pv, em, want;
    logic [W-1:0] pk;
    int last_cyc;
    last_cyc = 0;
    for (int i = 0; i < N; i++) begin
      q[i].push_back({8'h00, 8'($urandom_range(0, 255))});
      q[i].push_back({8'h00, 8'($urandom_range(0, 255))});
    end
    drive();
    for (int k = 0; k < 8; k++) begin
      wait_pop("fair", pv);
      want = '0;
      want[order[k]] = 1'b1;
      checks++; if (pv !== want) begin errors++; $display("FAIL fair_pop[%0d]: got %b want %b", k, pv, want); end
      if (k > 0) begin
        checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL fair_spacing[%0d]: got %0d cycles want 3", k, cyc - last_cyc); end
      end
      last_cyc = cyc;
      pk = q[order[k]][0];
      em = model_push(order[k], pk);
      tick();
      checks++; if (push !== em) begin errors++; $display("FAIL fair_push[%0d]: got %b want %b", k, push, em); end
      checks++; if (D_push !== pk) begin errors++; $display("FAIL fair_dpush[%0d]: got %h want %h", k, D_push, pk); end
      m_last = order[k];
      account(em);
    end
    tick();
  endtask

  task automatic test_sparse();
    int order[3] = '{1, 3, 1};
    logic [N-1:0] pv, want, em;
    logic [W-1:0] pk;
    q[1].push_back(16'h0011);
    q[1].push_back(16'h0322);
    q[3].push_back(16'h0233);
    drive();
    for (int k = 0; k < 3; k++) begin
      wait_pop("sparse", pv);
      want = '0;
      want[order[k]] = 1'b1;
      checks++; if (pv !== want) begin errors++; $display("FAIL sparse_pop[%0d]: got %b want %b", k, pv, want); end
      pk = q[order[k]][0];
      em = model_push(order[k], pk);
      tick();
      checks++; if (push !== em) begin errors++; $display("FAIL sparse_push[%0d]: got %b want %b", k, push, em); end
      checks++; if (grant_id !== 4'(order[k])) begin errors++; $display("FAIL sparse_grant_id[%0d]: got %0d want %0d", k, grant_id, order[k]); end
      m_last = order[k];
      account(em);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] pv;
    q[0].push_back(16'h0299);
    drive();
    wait_pop("rst_mid", pv);
    checks++; if (pv !== 4'b0001) begin errors++; $display("FAIL rst_mid_pop: got %b want 0001", pv); end
    #2 reset = 1'b0;
    #1;
    defer_dev = -1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL rst_mid_pop_clear: got %b want 0000", pop); end
    checks++; if (push !== 4'b0000) begin errors++; $display("FAIL rst_mid_push_clear: got %b want 0000", push); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (D_push !== 16'h0000) begin errors++; $display("FAIL rst_mid_dpush: got %h want 0000", D_push); end
    checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL rst_mid_grant_id: got %0d want 0", grant_id); end
    q[2].push_back(16'h0133);
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (push !== 4'b0000) begin errors++; $display("FAIL rst_mid_hold_push: got %b want 0000", push); end
    reset = 1'b1;
    m_last = N - 1;
    exp_pkt = 0;
    exp_drop = 0;
    wait_pop("rst_release", pv);
    checks++; if (pv !== 4'b0001) begin errors++; $display("FAIL rst_release_pop: got %b want 0001", pv); end
    tick();
    checks++; if (push !== 4'b0100) begin errors++; $display("FAIL rst_release_push: got %b want 0100", push); end
    checks++; if (D_push !== 16'h0299) begin errors++; $display("FAIL rst_release_dpush: got %h want 0299", D_push); end
    m_last = 0;
    account(4'b0100);
    wait_pop("rst_next", pv);
    checks++; if (pv !== 4'b0100) begin errors++; $display("FAIL rst_next_pop: got %b want 0100", pv); end
    tick();
    checks++; if (push !== 4'b0010) begin errors++; $display("FAIL rst_next_push: got %b want 0010", push); end
    m_last = 2;
    account(4'b0010);
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pv, em, want;
    logic [W-1:0] pk;
    int d, last_cyc, added, guard;
    bit first, any;
    first = 1'b1;
    added = 0;
    guard = 0;
    last_cyc = 0;
    for (int n = 0; n < 24; n++) q[$urandom_range(0, N-1)].push_back(rand_pkt());
    drive();
    any = 1'b1;
    while (any && guard < 100) begin
      guard++;
      wait_pop("random", pv);
      if (pv == '0) break;
      d = model_pick(m_last);
      want = '0;
      if (d >= 0) want[d] = 1'b1;
      checks++; if (pv !== want) begin errors++; $display("FAIL random_pop: got %b want %b", pv, want); end
      if (!first) begin
        checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL random_spacing: got %0d cycles want 3", cyc - last_cyc); end
      end
      first = 1'b0;
      last_cyc = cyc;
      if (d < 0) break;
      pk = q[d][0];
      em = model_push(d, pk);
      tick();
      checks++; if (push !== em) begin errors++; $display("FAIL random_push: src %0d pkt %h got %b want %b", d, pk, push, em); end
      checks++; if (D_push !== pk) begin errors++; $display("FAIL random_dpush: got %h want %h", D_push, pk); end
      checks++; if (grant_id !== 4'(d)) begin errors++; $display("FAIL random_grant_id: got %0d want %0d", grant_id, d); end
      m_last = d;
      account(em);
      if (added < 8 && $urandom_range(0, 3) == 0) begin
        q[$urandom_range(0, N-1)].push_back(rand_pkt());
        drive();
        added++;
      end
      any = 1'b0;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) any = 1'b1;
    end
    tick();
    checks++; if (pndng !== 4'b0000) begin errors++; $display("FAIL random_drain: pndng %b want 0000", pndng); end
`ifdef BUS_SCHED_STATS_EN
    checks++; if (pkt_cnt !== 16'(exp_pkt)) begin errors++; $display("FAIL random_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL random_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
`endif
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_invalid_dest();
    test_fairness();
    test_sparse();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
